memarb: RTL and testbench
=========================

# memarb

Two-port memory arbiter sharing the single synchronous RAM port between the 6502 core and a DMA/debug requester. Sits between the core's address path (after the PC/address select) and the memory. It arbitrates each cycle, stalls the losing requester, and returns read data one cycle after a granted read. The CPU has fixed priority; DMA can lock the bus for bursts, and an optional starvation guard bounds DMA wait.

## Interface
- STARVE_MAX, 8: number of consecutive cycles DMA may be refused before it is forced onto the bus (only with the guard compiled in); range 1..255.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  CPU address (addr_t)
- cpu_wdata  in  8  CPU write data (data_t)
- cpu_gnt  out  1  CPU access accepted this cycle (core stalls when req & !gnt)
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  8  CPU read data
- dma_req, dma_we, dma_addr[16], dma_wdata[8]  in  DMA request fields, same meaning as CPU
- dma_lock  in  1  hold bus for DMA while asserted and granted
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid, dma_rdata[8]  out  DMA read return
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  16  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid the cycle after mem_en & !mem_we

## Operation
- FSM states (arb_state_t): ARB_IDLE, ARB_CPU, ARB_DMA_LOCK. State records the last owner; the grant itself is combinational from the current requests and the state.
- ARB_IDLE/ARB_CPU: cpu_req wins. Else dma_req wins. With dma_req & dma_lock granted, the next state is ARB_DMA_LOCK; otherwise the next state is ARB_CPU if the CPU was granted, else ARB_IDLE.
- ARB_DMA_LOCK: DMA is granted whenever dma_req; the CPU is refused even with cpu_req. The FSM exits to ARB_IDLE the first cycle dma_lock=0 or dma_req=0; that cycle is arbitrated normally.
- At most one grant per cycle; the grant is only asserted when the corresponding req=1. mem_en = cpu_gnt | dma_gnt. mem_* fields are driven from the granted requester; with no grant, all mem_* are 0.
- Read return: the rd_owner register (none/cpu/dma) captures the granted read. Next cycle the matching *_rvalid=1 and *_rdata=mem_rdata. The non-owner's rdata is 0. A write produces no rvalid.
- Back-to-back reads by alternating owners return in grant order, one per cycle, with no bubble.

## Timing
- Grant: same cycle as request (combinational). Read latency: 1 cycle from grant to rvalid. Write: committed at the grant edge.
- Reset (async assert, sync release by the system): state=ARB_IDLE, rd_owner=none, starve counter=0. All outputs are 0 while rst_n=0; the grants stay 0 regardless of requests.
- A reset during ARB_DMA_LOCK drops the lock immediately. A pending read return is discarded (no rvalid after reset).
- Simultaneous cpu_req and dma_req in ARB_IDLE: CPU wins (unless the guard forces DMA).

## Configuration
- MEMARB_STARVE_GUARD_EN defined: an 8-bit counter increments each cycle dma_req=1 & dma_gnt=0. It clears on dma_gnt or !dma_req and saturates at STARVE_MAX. When the counter equals STARVE_MAX, DMA wins the next arbitration over the CPU and the counter clears.
- MEMARB_STARVE_GUARD_EN undefined: no counter; strict CPU priority outside ARB_DMA_LOCK, so DMA may starve indefinitely.

## Structure
- The common_types package provides addr_t (16-bit), data_t (8-bit), arb_state_t, and rd_owner_t (RD_NONE, RD_CPU, RD_DMA).
- There is one natural sub-module, memarb_fsm: state, lock, and starvation counter, producing cpu_gnt/dma_gnt. memarb wraps it with the mem_* field mux and the read-return routing.

## Test plan
- Reset: rst_n=0 with both requests high -> all outputs 0. After release, CPU read 0x1234 -> mem_addr=0x1234, cpu_gnt=1, cpu_rvalid=1 next cycle with the RAM byte.
- Contention: cpu_req and dma_req both high, guard off -> cpu_gnt=1 and dma_gnt=0 every cycle. Drop cpu_req -> dma_gnt=1 the same cycle.
- Lock burst: DMA writes 0x00..0x03 to 0x0200..0x0203 with dma_lock=1 while cpu_req=1 -> four dma_gnt cycles, cpu_gnt=0. Release the lock -> CPU is granted the next cycle.
- Read ordering: CPU read 0x0010, then DMA read 0x0020 on the next cycle -> cpu_rvalid then dma_rvalid on consecutive cycles, each carrying its own data.
- Starvation guard (MEMARB_STARVE_GUARD_EN, STARVE_MAX=4): cpu_req held high, dma_req high -> dma_gnt=1 on the 5th cycle, then the CPU resumes.
- Async reset asserted mid-lock with a read in flight -> state ARB_IDLE, no rvalid, grants 0.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared types for the memory arbiter: address/data widths, arbiter state and read-return owner.
package common_types;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_CPU      = 2'd1,
    ARB_DMA_LOCK = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DMA  = 2'd2
  } rd_owner_t;

  typedef struct packed {
    logic  en;
    logic  we;
    addr_t addr;
    data_t wdata;
  } mem_cmd_t;

  localparam mem_cmd_t MEM_CMD_IDLE = '{en: 1'b0, we: 1'b0, addr: '0, wdata: '0};

  function automatic mem_cmd_t make_cmd(input logic we, input addr_t addr, input data_t wdata);
    mem_cmd_t c;
    c.en    = 1'b1;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/memarb_fsm.sv
// Grant logic for the CPU/DMA arbiter: owner state, DMA bus lock and (with
// MEMARB_STARVE_GUARD_EN) the DMA starvation counter.
module memarb_fsm
  import common_types::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  input  logic       i_dma_lock,
  output logic       o_cpu_gnt,
  output logic       o_dma_gnt,
  output arb_state_t o_state
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("memarb_fsm: STARVE_MAX must be in 1..255");
  end

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       w_cpu_gnt;
  logic       w_dma_gnt;
  logic       w_force_dma;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_CNT_MAX = 8'(STARVE_MAX);

  logic [7:0] r_starve_cnt;

  // Counts refused DMA cycles; reaching the limit forces the next grant to DMA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 8'd0;
    end else if (!i_dma_req || w_dma_gnt) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt != STARVE_CNT_MAX) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  assign w_force_dma = i_dma_req && (r_starve_cnt == STARVE_CNT_MAX);
`else
  assign w_force_dma = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_state_nxt = ARB_IDLE;
    if (rst_n) begin
      if (r_state == ARB_DMA_LOCK && i_dma_req && i_dma_lock) begin
        w_dma_gnt   = 1'b1;
        w_state_nxt = ARB_DMA_LOCK;
      end else begin
        if (w_force_dma) begin
          w_dma_gnt = 1'b1;
        end else if (i_cpu_req) begin
          w_cpu_gnt = 1'b1;
        end else if (i_dma_req) begin
          w_dma_gnt = 1'b1;
        end
        // Leaving a lock always lands in IDLE, even if this cycle grants someone.
        if (r_state == ARB_DMA_LOCK) begin
          w_state_nxt = ARB_IDLE;
        end else if (w_dma_gnt && i_dma_lock) begin
          w_state_nxt = ARB_DMA_LOCK;
        end else if (w_cpu_gnt) begin
          w_state_nxt = ARB_CPU;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
    end
  end

  assign o_cpu_gnt = w_cpu_gnt;
  assign o_dma_gnt = w_dma_gnt;
  assign o_state   = r_state;

endmodule

// File: rtl/memarb.sv
// Two-port arbiter sharing one synchronous RAM port between the CPU and a DMA
// requester. Optional starvation guard: MEMARB_STARVE_GUARD_EN.
module memarb
  import common_types::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cpu_req,
  input  logic       i_cpu_we,
  input  addr_t      i_cpu_addr,
  input  data_t      i_cpu_wdata,
  output logic       o_cpu_gnt,
  output logic       o_cpu_rvalid,
  output data_t      o_cpu_rdata,
  input  logic       i_dma_req,
  input  logic       i_dma_we,
  input  addr_t      i_dma_addr,
  input  data_t      i_dma_wdata,
  input  logic       i_dma_lock,
  output logic       o_dma_gnt,
  output logic       o_dma_rvalid,
  output data_t      o_dma_rdata,
  output logic       o_mem_en,
  output logic       o_mem_we,
  output addr_t      o_mem_addr,
  output data_t      o_mem_wdata,
  input  data_t      i_mem_rdata,
  output arb_state_t o_dbg_state
);

  // Request/grant: a requester holds req and its fields stable until it sees
  // gnt in the same cycle; the access is taken on that clock edge. A granted
  // read returns rvalid/rdata exactly one cycle later, no back-pressure.

  logic      w_cpu_gnt;
  logic      w_dma_gnt;
  mem_cmd_t  w_mem_cmd;
  rd_owner_t r_rd_owner;

  memarb_fsm #(
    .STARVE_MAX(STARVE_MAX)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cpu_req (i_cpu_req),
    .i_dma_req (i_dma_req),
    .i_dma_lock(i_dma_lock),
    .o_cpu_gnt (w_cpu_gnt),
    .o_dma_gnt (w_dma_gnt),
    .o_state   (o_dbg_state)
  );

  always_comb begin
    w_mem_cmd = MEM_CMD_IDLE;
    if (w_cpu_gnt) begin
      w_mem_cmd = make_cmd(i_cpu_we, i_cpu_addr, i_cpu_wdata);
    end else if (w_dma_gnt) begin
      w_mem_cmd = make_cmd(i_dma_we, i_dma_addr, i_dma_wdata);
    end
  end

  assign o_mem_en    = w_mem_cmd.en;
  assign o_mem_we    = w_mem_cmd.we;
  assign o_mem_addr  = w_mem_cmd.addr;
  assign o_mem_wdata = w_mem_cmd.wdata;

  // Remembers who issued this cycle's read so the RAM's next-cycle data is routed back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= RD_NONE;
    end else if (w_cpu_gnt && !i_cpu_we) begin
      r_rd_owner <= RD_CPU;
    end else if (w_dma_gnt && !i_dma_we) begin
      r_rd_owner <= RD_DMA;
    end else begin
      r_rd_owner <= RD_NONE;
    end
  end

  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_dma_gnt    = w_dma_gnt;
  assign o_cpu_rvalid = (r_rd_owner == RD_CPU);
  assign o_dma_rvalid = (r_rd_owner == RD_DMA);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
  assign o_dma_rdata  = o_dma_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_memarb.sv
// Self-checking bench for memarb: directed sequences, a grant table and random
// traffic checked against a transaction-level model of the arbiter.
module tb_memarb;
  import common_types::*;

  localparam int SMAX = 4;
`ifdef MEMARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  arb_state_t  dbg_state;

  memarb #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .i_dma_lock(dma_lock),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM environment ----------------
  logic [7:0] ram    [0:65535];
  bit         ram_wr [0:65535];

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  // Read data is garbage unless a read was issued, so leaks into rdata show up.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_byte(mem_addr);
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] shadow [int];
  bit         m_locked;
  int         m_starve;
  int         m_pend;        // 0 none, 1 cpu, 2 dma
  logic [7:0] m_pend_data;
  logic       e_cg, e_dg;

  function automatic logic [7:0] shadow_rd(input logic [15:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_byte(a);
  endfunction

  task automatic model_grant();
    e_cg = 1'b0;
    e_dg = 1'b0;
    if (rst_n) begin
      if (m_locked && dma_req && dma_lock)                 e_dg = 1'b1;
      else if (GUARD && dma_req && m_starve >= SMAX)       e_dg = 1'b1;
      else if (cpu_req)                                    e_cg = 1'b1;
      else if (dma_req)                                    e_dg = 1'b1;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_locked = 1'b0;
      m_starve = 0;
      m_pend   = 0;
    end else begin
      m_pend = 0;
      if (e_cg && !cpu_we) begin m_pend = 1; m_pend_data = shadow_rd(cpu_addr); end
      if (e_dg && !dma_we) begin m_pend = 2; m_pend_data = shadow_rd(dma_addr); end
      if (e_cg && cpu_we) shadow[int'(cpu_addr)] = cpu_wdata;
      if (e_dg && dma_we) shadow[int'(dma_addr)] = dma_wdata;
      m_locked = e_dg && dma_lock;
      if (dma_req && !e_dg) m_starve = (m_starve < SMAX) ? m_starve + 1 : m_starve;
      else                  m_starve = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic       s_cg, s_dg, s_crv, s_drv, s_men, s_mwe;
  logic [7:0] s_crd, s_drd, s_mwd;
  logic [15:0] s_madr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] ewe, eadr, ewd;
    model_grant();
    s_cg = cpu_gnt;  s_dg = dma_gnt;  s_crv = cpu_rvalid; s_drv = dma_rvalid;
    s_crd = cpu_rdata; s_drd = dma_rdata; s_men = mem_en; s_mwe = mem_we;
    s_madr = mem_addr; s_mwd = mem_wdata;
    ewe  = e_cg ? 32'(cpu_we)    : e_dg ? 32'(dma_we)    : 32'd0;
    eadr = e_cg ? 32'(cpu_addr)  : e_dg ? 32'(dma_addr)  : 32'd0;
    ewd  = e_cg ? 32'(cpu_wdata) : e_dg ? 32'(dma_wdata) : 32'd0;
    chk("cpu_gnt",   32'(s_cg),   32'(e_cg));
    chk("dma_gnt",   32'(s_dg),   32'(e_dg));
    chk("mem_en",    32'(s_men),  32'(e_cg | e_dg));
    chk("mem_we",    32'(s_mwe),  ewe);
    chk("mem_addr",  32'(s_madr), eadr);
    chk("mem_wdata", 32'(s_mwd),  ewd);
    chk("cpu_rvalid", 32'(s_crv), 32'(rst_n && m_pend == 1));
    chk("cpu_rdata",  32'(s_crd), (rst_n && m_pend == 1) ? 32'(m_pend_data) : 32'd0);
    chk("dma_rvalid", 32'(s_drv), 32'(rst_n && m_pend == 2));
    chk("dma_rdata",  32'(s_drd), (rst_n && m_pend == 2) ? 32'(m_pend_data) : 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd,
                       input logic dl);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0);
    cycle();
  endtask

  // ---------------- grant table ----------------
  typedef struct {
    logic cr, cw, dr, dw, dl;
    logic e_cg, e_dg;
  } vec_t;
  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // lock taken
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // locked, CPU refused
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // lock dropped
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};  // dma_req low ends lock

    m_locked = 1'b0; m_starve = 0; m_pend = 0; m_pend_data = 8'h0;
    e_cg = 1'b0; e_dg = 1'b0;

    // Reset with both requesters active: everything quiet.
    rst_n = 1'b0;
    drive(1, 0, 16'h1111, 8'h11, 1, 0, 16'h2222, 8'h22, 1);
    cycle();
    chk("rst_cpu_gnt", 32'(s_cg), 32'd0);
    chk("rst_dma_gnt", 32'(s_dg), 32'd0);
    chk("rst_state",   32'(dbg_state), 32'(ARB_IDLE));
    cycle();
    rst_n = 1'b1;

    // First CPU read after reset.
    drive(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h0, 0);
    cycle();
    chk("rd1234_addr", 32'(s_madr), 32'h1234);
    chk("rd1234_gnt",  32'(s_cg), 32'd1);
    idle();
    chk("rd1234_rvalid", 32'(s_crv), 32'd1);
    chk("rd1234_rdata",  32'(s_crd), 32'h7C);

    // Contention: CPU keeps the bus, then DMA the moment CPU lets go.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 16'h0040, 8'h0, 1, 0, 16'h0050, 8'h0, 0);
      cycle();
      chk("cont_cpu_gnt", 32'(s_cg), 32'd1);
      chk("cont_dma_gnt", 32'(s_dg), 32'd0);
    end
    drive(0, 0, 16'h0040, 8'h0, 1, 0, 16'h0050, 8'h0, 0);
    cycle();
    chk("cont_dma_takeover", 32'(s_dg), 32'd1);

    // Locked DMA write burst with the CPU requesting throughout.
    for (int k = 0; k < 4; k++) begin
      drive(k != 0, 0, 16'h0060, 8'h0, 1, 1, 16'h0200 + 16'(k), 8'(k), 1);
      cycle();
      chk("burst_dma_gnt", 32'(s_dg), 32'd1);
      chk("burst_cpu_gnt", 32'(s_cg), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1, 0, 16'h0200 + 16'(k), 8'h0, 0, 0, 16'h0, 8'h0, 0);
      else       drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0);
      cycle();
      if (k == 0) chk("unlock_cpu_gnt", 32'(s_cg), 32'd1);
      if (k > 0) begin
        chk("burst_rb_rvalid", 32'(s_crv), 32'd1);
        chk("burst_rb_rdata",  32'(s_crd), 32'(k - 1));
      end
    end

    // Alternating-owner reads return in grant order, back to back.
    drive(1, 1, 16'h0010, 8'hA5, 0, 0, 16'h0, 8'h0, 0); cycle();
    drive(0, 0, 16'h0, 8'h0, 1, 1, 16'h0020, 8'h3C, 0); cycle();
    drive(1, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0, 0);  cycle();
    drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 0);  cycle();
    chk("order_cpu_rvalid", 32'(s_crv), 32'd1);
    chk("order_cpu_rdata",  32'(s_crd), 32'hA5);
    chk("order_dma_idle",   32'(s_drv), 32'd0);
    idle();
    chk("order_dma_rvalid", 32'(s_drv), 32'd1);
    chk("order_dma_rdata",  32'(s_drd), 32'h3C);
    chk("order_cpu_done",   32'(s_crv), 32'd0);
    chk("order_cpu_rdata0", 32'(s_crd), 32'd0);

    // Grant table from an idle, unlocked arbiter.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].cr, tbl[i].cw, 16'h0100 + 16'(i), 8'(i),
            tbl[i].dr, tbl[i].dw, 16'h0300 + 16'(i), 8'(8'h80 + i), tbl[i].dl);
      cycle();
      chk("tbl_cpu_gnt", 32'(s_cg), 32'(tbl[i].e_cg));
      chk("tbl_dma_gnt", 32'(s_dg), 32'(tbl[i].e_dg));
    end
    idle();

    // Sustained contention: DMA forced in after SMAX refusals only with the guard.
    for (int k = 0; k < SMAX + 2; k++) begin
      drive(1, 0, 16'h0030, 8'h0, 1, 0, 16'h0031, 8'h0, 0);
      cycle();
      chk("starve_dma_gnt", 32'(s_dg), 32'(GUARD && k == SMAX));
      chk("starve_cpu_gnt", 32'(s_cg), 32'(!(GUARD && k == SMAX)));
    end
    idle();

    // Async reset mid-lock with a DMA read outstanding.
    drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 1); cycle();
    drive(1, 0, 16'h0044, 8'h0, 1, 0, 16'h0021, 8'h0, 1); cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    chk("arst_dma_gnt",    32'(dma_gnt), 32'd0);
    chk("arst_cpu_gnt",    32'(cpu_gnt), 32'd0);
    chk("arst_mem_en",     32'(mem_en), 32'd0);
    chk("arst_state",      32'(dbg_state), 32'(ARB_IDLE));
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("arst_lock_dropped", 32'(s_cg), 32'd1);
    chk("arst_no_rvalid",    32'(s_drv), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom),
            $urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom),
            $urandom_range(0, 3) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
